karatsuba_mult_pipe: RTL and testbench

- Parametrised, pipelined one-level Karatsuba unsigned multiplier. Computes the full 2*WIDTH-bit product of two WIDTH-bit operands.
- Uses three half-width multiplies: high, low and cross-sum.
- Valid/ready streaming interface with backpressure. Drop-in registered replacement for the combinational 64x64 multiplier in the FPGA datapath.

---
 rtl/kmult_pkg.sv | 18 +
 rtl/kmult_pp_stage.sv | 49 ++++
 rtl/karatsuba_mult_pipe.sv | 146 ++++++++++++++
 tb/tb_karatsuba_mult_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmult_pkg.sv
// Shared sizing helpers for the one-level Karatsuba multiplier pipeline.
// Optional sideband tag support is enabled with the KMULT_TAG_EN macro.
package kmult_pkg;

  // Number of register stages between operand capture and the result
  localparam int KMULT_STAGES = 3;

  // Width of one operand half
  function automatic int kmult_half(input int width);
    return width / 2;
  endfunction

  // Width of a half-sum (a1+a0), one extra bit so the carry is never lost
  function automatic int kmult_sum_w(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/kmult_pp_stage.sv
// Partial-product register of the Karatsuba pipeline.
// Holds z2 = a1*b1, z0 = a0*b0 and z1 = (a1+a0)*(b1+b0) as three independent
// multiplies so each can map onto its own DSP block.
module kmult_pp_stage
  import kmult_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic [kmult_half(WIDTH)-1:0]   a1_i,
  input  logic [kmult_half(WIDTH)-1:0]   a0_i,
  input  logic [kmult_half(WIDTH)-1:0]   b1_i,
  input  logic [kmult_half(WIDTH)-1:0]   b0_i,
  input  logic [kmult_sum_w(WIDTH)-1:0]  sa_i,
  input  logic [kmult_sum_w(WIDTH)-1:0]  sb_i,
  output logic [WIDTH-1:0]               z2_o,
  output logic [WIDTH-1:0]               z0_o,
  output logic [WIDTH+1:0]               z1_o
);

  localparam int H  = kmult_half(WIDTH);
  localparam int SW = kmult_sum_w(WIDTH);

  logic [WIDTH-1:0] z2_d, z2_q;
  logic [WIDTH-1:0] z0_d, z0_q;
  logic [WIDTH+1:0] z1_d, z1_q;

  // Three half-width products, operands widened to the product width first
  always_comb begin
    z2_d = {{H{1'b0}}, a1_i} * {{H{1'b0}}, b1_i};
    z0_d = {{H{1'b0}}, a0_i} * {{H{1'b0}}, b0_i};
    z1_d = {{SW{1'b0}}, sa_i} * {{SW{1'b0}}, sb_i};
  end

  // Product register; contents only matter when the matching valid bit is set
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      z2_q <= z2_d;
      z0_q <= z0_d;
      z1_q <= z1_d;
    end
  end

  assign z2_o = z2_q;
  assign z0_o = z0_q;
  assign z1_o = z1_q;

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// Pipelined one-level Karatsuba unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Stages: S0 operand halves and sums, S1 partial products, S2 combined result.
// The whole pipe stalls together when the output is held and not accepted.
// Define KMULT_TAG_EN to add the IN_TAG/OUT_TAG sideband travelling with data.
module karatsuba_mult_pipe
  import kmult_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     IN1,
  input  logic [WIDTH-1:0]     IN2,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
`ifdef KMULT_TAG_EN
  input  logic [TAG_W-1:0]     IN_TAG,
  output logic [TAG_W-1:0]     OUT_TAG,
`endif
  output logic [2*WIDTH-1:0]   OUTPUT
);

  localparam int H  = kmult_half(WIDTH);
  localparam int SW = kmult_sum_w(WIDTH);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("karatsuba_mult_pipe: WIDTH must be even and >= 4");
  end

  if (TAG_W < 1) begin : g_bad_tag
    $error("karatsuba_mult_pipe: TAG_W must be >= 1");
  end

  typedef struct packed {
    logic [H-1:0]  a1;
    logic [H-1:0]  a0;
    logic [H-1:0]  b1;
    logic [H-1:0]  b0;
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
  } s0_rec_t;

  logic                    advance;
  logic [KMULT_STAGES-1:0] vld_d, vld_q;
  s0_rec_t                 s0_d, s0_q;
  logic [WIDTH-1:0]        z2, z0;
  logic [WIDTH+1:0]        z1;
  logic [WIDTH+1:0]        mid;
  logic [2*WIDTH-1:0]      out_d, out_q;

  assign advance   = !vld_q[KMULT_STAGES-1] || OUT_READY;
  assign IN_READY  = advance;
  assign OUT_VALID = vld_q[KMULT_STAGES-1];

  // Valid bits shift in lockstep with the data; an idle input injects a bubble
  always_comb begin
    vld_d = {vld_q[KMULT_STAGES-2:0], IN_VALID};
  end

  // Valid shift register: cleared at once on reset, frozen during a stall
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= vld_d;
    end
  end

  // Split operands into halves and form the carry-preserving half sums
  always_comb begin
    s0_d    = '0;
    s0_d.a1 = IN1[WIDTH-1:H];
    s0_d.a0 = IN1[H-1:0];
    s0_d.b1 = IN2[WIDTH-1:H];
    s0_d.b0 = IN2[H-1:0];
    s0_d.sa = {1'b0, IN1[WIDTH-1:H]} + {1'b0, IN1[H-1:0]};
    s0_d.sb = {1'b0, IN2[WIDTH-1:H]} + {1'b0, IN2[H-1:0]};
  end

  // S0 operand register; bubbles carry don't-care data marked invalid
  always_ff @(posedge CLK) begin
    if (advance) begin
      s0_q <= s0_d;
    end
  end

  kmult_pp_stage #(
    .WIDTH (WIDTH)
  ) u_pp_stage (
    .clk_i (CLK),
    .en_i  (advance),
    .a1_i  (s0_q.a1),
    .a0_i  (s0_q.a0),
    .b1_i  (s0_q.b1),
    .b0_i  (s0_q.b0),
    .sa_i  (s0_q.sa),
    .sb_i  (s0_q.sb),
    .z2_o  (z2),
    .z0_o  (z0),
    .z1_o  (z1)
  );

  // Recombine: mid = a1*b0 + a0*b1 is never negative and fits the product
  always_comb begin
    mid   = z1 - {2'b00, z2} - {2'b00, z0};
    out_d = {z2, z0} + ({{(WIDTH-2){1'b0}}, mid} << H);
  end

  // Output register is visible on the port, so it is cleared on reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q <= '0;
    end else if (advance) begin
      out_q <= out_d;
    end
  end

  assign OUTPUT = out_q;

`ifdef KMULT_TAG_EN
  logic [TAG_W-1:0] tag0_q, tag1_q, tag2_q;

  // Tag follows its operands through S0 and S1 under the same stall rule
  always_ff @(posedge CLK) begin
    if (advance) begin
      tag0_q <= IN_TAG;
      tag1_q <= tag0_q;
    end
  end

  // Output tag aligned with OUTPUT and cleared on reset like it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag2_q <= '0;
    end else if (advance) begin
      tag2_q <= tag1_q;
    end
  end

  assign OUT_TAG = tag2_q;
`endif

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Directed testbench for karatsuba_mult_pipe at WIDTH=64.
// Tag checks are compiled in when KMULT_TAG_EN is defined.
module tb_karatsuba_mult_pipe;

  localparam int WIDTH = 64;
  localparam int TAG_W = 8;
  localparam int NDIR  = 12;
  localparam int NVEC  = 32;

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                IN_VALID = 1'b0;
  logic                IN_READY;
  logic [WIDTH-1:0]    IN1 = '0;
  logic [WIDTH-1:0]    IN2 = '0;
  logic                OUT_VALID;
  logic                OUT_READY = 1'b1;
  logic [2*WIDTH-1:0]  OUTPUT;
`ifdef KMULT_TAG_EN
  logic [TAG_W-1:0]    IN_TAG = '0;
  logic [TAG_W-1:0]    OUT_TAG;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0]   vA [NVEC];
  logic [WIDTH-1:0]   vB [NVEC];
  logic [2*WIDTH-1:0] vP [NVEC];

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CLK = ~CLK;

  karatsuba_mult_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN1       (IN1),
    .IN2       (IN2),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
`ifdef KMULT_TAG_EN
    .IN_TAG    (IN_TAG),
    .OUT_TAG   (OUT_TAG),
`endif
    .OUTPUT    (OUTPUT)
  );

  task automatic init_vectors();
    vA[0]  = 64'hFFFFFFFFFFFFFFFF; vB[0]  = 64'hFFFFFFFFFFFFFFFF;
    vP[0]  = 128'hFFFFFFFFFFFFFFFE0000000000000001;
    vA[1]  = 64'h0;                vB[1]  = 64'hFFFFFFFFFFFFFFFF;
    vP[1]  = 128'h0;
    vA[2]  = 64'd7;                vB[2]  = 64'd6;
    vP[2]  = 128'd42;
    vA[3]  = 64'h0000000100000000; vB[3]  = 64'h0000000100000000;
    vP[3]  = 128'h00000000000000010000000000000000;
    vA[4]  = 64'h00000000FFFFFFFF; vB[4]  = 64'h00000000FFFFFFFF;
    vP[4]  = 128'hFFFFFFFE00000001;
    vA[5]  = 64'hFFFFFFFF00000000; vB[5]  = 64'd2;
    vP[5]  = 128'h1FFFFFFFE00000000;
    vA[6]  = 64'h8000000000000000; vB[6]  = 64'h8000000000000000;
    vP[6]  = 128'h40000000000000000000000000000000;
    vA[7]  = 64'h0000000123456789; vB[7]  = 64'h10;
    vP[7]  = 128'h1234567890;
    vA[8]  = 64'hFFFFFFFFFFFFFFFF; vB[8]  = 64'd2;
    vP[8]  = 128'h1FFFFFFFFFFFFFFFE;
    vA[9]  = 64'h00000000FFFFFFFF; vB[9]  = 64'hFFFFFFFF00000000;
    vP[9]  = 128'hFFFFFFFE0000000100000000;
    vA[10] = 64'hFFFFFFFF00000000; vB[10] = 64'hFFFFFFFF00000000;
    vP[10] = 128'hFFFFFFFE000000010000000000000000;
    vA[11] = 64'd3;                vB[11] = 64'd5;
    vP[11] = 128'd15;
    for (int i = NDIR; i < NVEC; i++) begin
      vA[i] = {$urandom, $urandom};
      vB[i] = {$urandom, $urandom};
      vP[i] = {64'b0, vA[i]} * {64'b0, vB[i]};
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #2;
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", OUT_VALID);
    end
    checks++;
    if (OUTPUT !== '0) begin
      errors++; $display("[TB] FAIL reset_output: got %h expected 0", OUTPUT);
    end
`ifdef KMULT_TAG_EN
    checks++;
    if (OUT_TAG !== '0) begin
      errors++; $display("[TB] FAIL reset_out_tag: got %h expected 0", OUT_TAG);
    end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", IN_READY);
    end
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_out_valid: got %b expected 0", OUT_VALID);
    end
  endtask

  task automatic test_single_max();
    OUT_READY = 1'b1;
    @(negedge CLK);
    IN1 = vA[0]; IN2 = vB[0]; IN_VALID = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      IN_VALID = 1'b0;
      #1;
      checks++;
      if (OUT_VALID !== (c == 3)) begin
        errors++; $display("[TB] FAIL single_valid_c%0d: got %b expected %b", c, OUT_VALID, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (OUTPUT !== vP[0]) begin
          errors++; $display("[TB] FAIL single_max_product: got %h expected %h", OUTPUT, vP[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    OUT_READY = 1'b1;
    for (int c = 0; c < NVEC + 4; c++) begin
      @(negedge CLK);
      IN_VALID = (c < NVEC);
      if (c < NVEC) begin
        IN1 = vA[c]; IN2 = vB[c];
`ifdef KMULT_TAG_EN
        IN_TAG = TAG_W'(c + 8'h40);
`endif
      end
      #1;
      checks++;
      if (IN_READY !== 1'b1) begin
        errors++; $display("[TB] FAIL stream_in_ready_c%0d: got %b expected 1", c, IN_READY);
      end
      checks++;
      if (OUT_VALID !== (c >= 3 && c < NVEC + 3)) begin
        errors++; $display("[TB] FAIL stream_valid_c%0d: got %b expected %b", c, OUT_VALID, (c >= 3 && c < NVEC + 3));
      end
      if (c >= 3 && c < NVEC + 3) begin
        checks++;
        if (OUTPUT !== vP[c-3]) begin
          errors++; $display("[TB] FAIL stream_product_%0d: got %h expected %h", c - 3, OUTPUT, vP[c-3]);
        end
`ifdef KMULT_TAG_EN
        checks++;
        if (OUT_TAG !== TAG_W'(c - 3 + 8'h40)) begin
          errors++; $display("[TB] FAIL stream_tag_%0d: got %h expected %h", c - 3, OUT_TAG, TAG_W'(c - 3 + 8'h40));
        end
`endif
      end
    end
  endtask

  task automatic test_backpressure();
    int inIdx = 0;
    int outIdx = 0;
    int cyc = 0;
    while (outIdx < 5 && cyc < 60) begin
      @(negedge CLK);
      OUT_READY = (cyc >= 13);
      IN_VALID = (inIdx < 5);
      if (inIdx < 5) begin
        IN1 = vA[inIdx + 5]; IN2 = vB[inIdx + 5];
      end
      #1;
      if (cyc >= 3 && cyc < 13) begin
        checks++;
        if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUTPUT !== vP[5]) begin
          errors++;
          $display("[TB] FAIL stall_hold_c%0d: got ready=%b valid=%b out=%h expected ready=0 valid=1 out=%h",
                   cyc, IN_READY, OUT_VALID, OUTPUT, vP[5]);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        checks++;
        if (OUTPUT !== vP[outIdx + 5]) begin
          errors++; $display("[TB] FAIL stall_order_%0d: got %h expected %h", outIdx, OUTPUT, vP[outIdx + 5]);
        end
        outIdx++;
      end
      if (IN_VALID && IN_READY) inIdx++;
      cyc++;
    end
    IN_VALID = 1'b0;
    checks++;
    if (outIdx != 5) begin
      errors++; $display("[TB] FAIL stall_timeout: got %0d results expected 5", outIdx);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      #1;
      checks++;
      if (OUT_VALID !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_duplicate_c%0d: got %b expected 0", c, OUT_VALID);
      end
    end
  endtask

  task automatic test_reset_midflight();
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1; IN1 = vA[9 + i]; IN2 = vB[9 + i];
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b1 || OUTPUT !== vP[9]) begin
      errors++; $display("[TB] FAIL midflight_pre: got valid=%b out=%h expected valid=1 out=%h", OUT_VALID, OUTPUT, vP[9]);
    end
    #1;
    RST_N = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || OUTPUT !== '0 || IN_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL midflight_async_clear: got valid=%b out=%h ready=%b expected 0 0 1", OUT_VALID, OUTPUT, IN_READY);
    end
`ifdef KMULT_TAG_EN
    checks++;
    if (OUT_TAG !== '0) begin
      errors++; $display("[TB] FAIL midflight_tag_clear: got %h expected 0", OUT_TAG);
    end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      #1;
      checks++;
      if (OUT_VALID !== 1'b0) begin
        errors++; $display("[TB] FAIL midflight_stale_c%0d: got %b expected 0", c, OUT_VALID);
      end
    end
    @(negedge CLK);
    IN_VALID = 1'b1; IN1 = 64'd7; IN2 = 64'd6;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      IN_VALID = 1'b0;
      #1;
      checks++;
      if (OUT_VALID !== (c == 3)) begin
        errors++; $display("[TB] FAIL midflight_latency_c%0d: got %b expected %b", c, OUT_VALID, (c == 3));
      end
    end
    checks++;
    if (OUTPUT !== 128'd42) begin
      errors++; $display("[TB] FAIL midflight_7x6: got %0d expected 42", OUTPUT);
    end
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_single_max();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
